// File: rtl/red_pitaya_fads_pkg.sv
// Shared types and helpers for the FADS sort-pulse scheduler.
// Holds the FSM encoding, default widths and the wrap-safe due-time compare.
package red_pitaya_fads_pkg;

    localparam int unsigned TW_DEF         = 32;
    localparam int unsigned DEPTH_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } fsm_state_e;

    // A due time has been reached when (now - due) is non-negative in w-bit
    // two's complement; only valid while delays stay below half the range.
    function automatic logic is_due(input logic [63:0] now_v,
                                    input logic [63:0] due_v,
                                    input int unsigned w);
        logic [63:0] diff;
        logic [63:0] sh;
        diff = now_v - due_v;
        sh   = diff >> (w - 1);
        return ~sh[0];
    endfunction

endpackage

// File: rtl/red_pitaya_fads_due_fifo.sv
// Purpose: synchronous FIFO of due time-stamps with flush.
// Latency: a push is visible at head/count the cycle after the write edge.
// Backpressure: push ignored while full, pop ignored while empty; flush wins.
module red_pitaya_fads_due_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [DW-1:0] head
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/red_pitaya_fads_sort_sched.sv
// Purpose: time-stamps sort requests and drives the sort trigger with programmed length and gap.
// Latency: trigger rises max(delay,1)+1 cycles after a request when idle; FADS_SCHED_MERGE_EN merges overlapping pulses.
// Backpressure: req_ready_o low when the queue is full; requests then are dropped and counted.
module red_pitaya_fads_sort_sched
    import red_pitaya_fads_pkg::*;
#(
    parameter int unsigned    DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned    TW         = TW_DEF,
    parameter logic [TW-1:0]  NOW_RST    = '0
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  req_i,
    output logic                  req_ready_o,
    input  logic [TW-1:0]         sort_delay_i,
    input  logic [TW-1:0]         sort_duration_i,
    input  logic [TW-1:0]         min_gap_i,
    output logic                  sort_trig_o,
    output logic                  busy_o,
    output logic [DEPTH_LOG2:0]   pending_o,
    output logic [TW-1:0]         fired_cnt_o,
    output logic [TW-1:0]         dropped_cnt_o
);

    fsm_state_e          state_q, state_d;
    logic [TW-1:0]       now_q, now_d;
    logic [TW-1:0]       dur_q, dur_d;
    logic [TW-1:0]       gap_q, gap_d;
    logic [TW-1:0]       fired_q, fired_d;
    logic [TW-1:0]       dropped_q, dropped_d;
    logic                trig_q, trig_d;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [TW-1:0]       fifo_head, due_time;
    logic                push, pop, head_due;
    logic [TW-1:0]       dur_load;

    red_pitaya_fads_due_fifo #(
        .DW (TW),
        .AW (DEPTH_LOG2)
    ) u_due_fifo (
        .clk      (adc_clk_i),
        .rst_n    (adc_rstn_i),
        .flush    (clear_i),
        .push     (push),
        .pop      (pop),
        .push_dat (due_time),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    always_comb begin
        now_d    = now_q + TW'(1);
        due_time = now_q + sort_delay_i;
        dur_load = (sort_duration_i == '0) ? TW'(1) : sort_duration_i;
        head_due = !fifo_empty && is_due(64'(now_q), 64'(fifo_head), TW);
        push     = req_i && enable_i && !fifo_full && !clear_i;
    end

    always_comb begin
        state_d   = state_q;
        trig_d    = trig_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        fired_d   = fired_q;
        dropped_d = dropped_q;
        pop       = 1'b0;
        if (clear_i) begin
            state_d   = ST_IDLE;
            trig_d    = 1'b0;
            dur_d     = '0;
            gap_d     = '0;
            fired_d   = '0;
            dropped_d = '0;
        end else begin
            // a full queue drops the request even if a pop frees a slot this cycle
            if (req_i && enable_i && fifo_full && dropped_q != '1)
                dropped_d = dropped_q + TW'(1);
            case (state_q)
                ST_IDLE: begin
                    if (head_due) begin
                        pop     = 1'b1;
                        dur_d   = dur_load;
                        trig_d  = 1'b1;
                        state_d = ST_PULSE;
                        if (fired_q != '1) fired_d = fired_q + TW'(1);
                    end
                end
                ST_PULSE: begin
`ifdef FADS_SCHED_MERGE_EN
                    if (head_due) begin
                        pop   = 1'b1;
                        dur_d = dur_load;
                        if (fired_q != '1) fired_d = fired_q + TW'(1);
                    end else
`endif
                    if (dur_q == TW'(1)) begin
                        trig_d  = 1'b0;
                        gap_d   = min_gap_i;
                        state_d = (min_gap_i != '0) ? ST_GAP : ST_IDLE;
                    end else begin
                        dur_d = dur_q - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == TW'(1)) state_d = ST_IDLE;
                    else                 gap_d   = gap_q - TW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            now_q     <= NOW_RST;
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            dur_q     <= '0;
            gap_q     <= '0;
            fired_q   <= '0;
            dropped_q <= '0;
        end else begin
            now_q     <= now_d;
            state_q   <= state_d;
            trig_q    <= trig_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            fired_q   <= fired_d;
            dropped_q <= dropped_d;
        end
    end

    assign sort_trig_o   = trig_q;
    assign req_ready_o   = !fifo_full;
    assign pending_o     = fifo_count;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
    assign fired_cnt_o   = fired_q;
    assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// Bench for the FADS sort scheduler: cycle-level event model plus directed literal checks.
// The time base starts near its wrap point so the early request exercises due-time wrap.
`timescale 1ns/1ps
module tb_red_pitaya_fads_sort_sched;

    localparam int TW    = 32;
    localparam int DL2   = 3;
    localparam int PW    = DL2 + 1;
    localparam int DEPTH = 8;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          en   = 1'b0;
    logic          clr  = 1'b0;
    logic          req  = 1'b0;
    logic [TW-1:0] dly  = '0;
    logic [TW-1:0] dur  = '0;
    logic [TW-1:0] gap  = '0;
    logic          trig, ready, busy;
    logic [DL2:0]  pend;
    logic [TW-1:0] fired, dropped;

    always #5 clk = ~clk;

    red_pitaya_fads_sort_sched #(
        .DEPTH_LOG2 (DL2),
        .TW         (TW),
        .NOW_RST    (32'hFFFF_FFE2)
    ) dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (rstn),
        .enable_i        (en),
        .clear_i         (clr),
        .req_i           (req),
        .req_ready_o     (ready),
        .sort_delay_i    (dly),
        .sort_duration_i (dur),
        .min_gap_i       (gap),
        .sort_trig_o     (trig),
        .busy_o          (busy),
        .pending_o       (pend),
        .fired_cnt_o     (fired),
        .dropped_cnt_o   (dropped)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    bit     chk_en  = 1'b0;

    // Model: queue of the earliest cycle each pending event may raise the trigger,
    // the current pulse window and the earliest cycle a new pulse may start.
    longint mq[$];
    longint t_start = 0, t_end = -1, next_ok = 0;
    longint m_fired = 0, m_dropped = 0;
    logic          e_trig = 1'b0, e_ready = 1'b1, e_busy = 1'b0;
    logic [DL2:0]  e_pend = '0;
    logic [TW-1:0] e_fired = '0, e_dropped = '0;

    task automatic model_reset();
        mq.delete();
        t_start = 0; t_end = -1; next_ok = 0;
        m_fired = 0; m_dropped = 0;
    endtask

    task automatic bump_fired();
        if (m_fired < 64'hFFFF_FFFF) m_fired++;
    endtask

    task automatic model_step(input longint c);
        bit     hi, headrdy, full, popped;
        longint dl, dd;
        hi      = (c >= t_start) && (c <= t_end);
        headrdy = (mq.size() > 0) && (mq[0] <= c + 1);
        full    = (mq.size() >= DEPTH);
        popped  = 1'b0;
        dl      = (dur == 0) ? 1 : longint'(dur);
        dd      = (dly == 0) ? 1 : longint'(dly);
        if (clr) begin
            model_reset();
        end else begin
            if (hi) begin
`ifdef FADS_SCHED_MERGE_EN
                if (headrdy) begin
                    void'(mq.pop_front());
                    t_end  = c + dl;
                    popped = 1'b1;
                    bump_fired();
                end
`endif
                if (!popped && c == t_end) next_ok = c + 2 + longint'(gap);
            end else if (c + 1 >= next_ok && headrdy) begin
                void'(mq.pop_front());
                t_start = c + 1;
                t_end   = c + dl;
                bump_fired();
            end
            if (req && en) begin
                if (full) begin
                    if (m_dropped < 64'hFFFF_FFFF) m_dropped++;
                end else begin
                    mq.push_back(c + dd + 1);
                end
            end
        end
    endtask

    task automatic model_outputs(input longint n);
        e_trig    = (n >= t_start) && (n <= t_end);
        e_pend    = PW'(mq.size());
        e_ready   = (mq.size() < DEPTH);
        e_busy    = e_trig || (n < next_ok - 1) || (mq.size() > 0);
        e_fired   = m_fired[TW-1:0];
        e_dropped = m_dropped[TW-1:0];
    endtask

    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step(cyc);
        model_outputs(cyc + 1);
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (trig !== e_trig || ready !== e_ready || busy !== e_busy ||
                pend !== e_pend || fired !== e_fired || dropped !== e_dropped) begin
                n_fail++;
                $display("FAIL cycle_model cyc=%0d got trig=%b rdy=%b busy=%b pend=%0d fired=%0d drop=%0d want trig=%b rdy=%b busy=%b pend=%0d fired=%0d drop=%0d",
                         cyc, trig, ready, busy, pend, fired, dropped,
                         e_trig, e_ready, e_busy, e_pend, e_fired, e_dropped);
            end
        end
    end

    longint rises[$];
    longint falls[$];
    logic   prev_trig = 1'b0;
    always @(negedge clk) begin
        if (trig && !prev_trig) rises.push_back(cyc);
        if (!trig && prev_trig) falls.push_back(cyc);
        prev_trig = trig;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        rises.delete();
        falls.delete();
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        while (busy && b > 0) begin
            tick(1);
            b--;
        end
        chk("drain_busy", busy, 0);
    endtask

    task automatic wait_rise(input int k, input int budget);
        int b;
        b = budget;
        while (rises.size() < k && b > 0) begin
            tick(1);
            b--;
        end
        if (rises.size() < k) chk("rise_timeout", rises.size(), k);
    endtask

    longint t0;
    int     n_r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_trig", trig, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend, 0);
        chk("rst_fired", fired, 0);
        chk("rst_dropped", dropped, 0);
        rstn = 1'b1;
        en   = 1'b1;
        tick(6);

        // wrap-around: time base sits a few cycles below 2^32
        dly = 50; dur = 5; gap = 0;
        req = 1'b1; t0 = cyc; tick(1); req = 1'b0;
        wait_idle(200);
        chk("wrap_npulse", rises.size(), 1);
        if (rises.size() >= 1) chk("wrap_latency", rises[0] - t0, 51);

        // single event
        do_clear();
        dly = 100; dur = 50; gap = 0;
        req = 1'b1; t0 = cyc; tick(1); req = 1'b0;
        wait_idle(400);
        chk("single_npulse", rises.size(), 1);
        if (rises.size() >= 1 && falls.size() >= 1) begin
            chk("single_latency", rises[0] - t0, 101);
            chk("single_width", falls[0] - rises[0], 50);
        end
        chk("single_fired", fired, 1);

        // two spaced requests
        do_clear();
        dly = 100; dur = 10; gap = 5;
        req = 1'b1; t0 = cyc; tick(1); req = 1'b0;
        tick(19);
        req = 1'b1; tick(1); req = 1'b0;
        wait_idle(400);
        chk("two_npulse", rises.size(), 2);
        if (rises.size() >= 2 && falls.size() >= 2) begin
            chk("two_start0", rises[0] - t0, 101);
            chk("two_start1", rises[1] - t0, 121);
            chk("two_width1", falls[1] - rises[1], 10);
        end

        // overlapping requests
        do_clear();
        dly = 100; dur = 30; gap = 4;
        req = 1'b1; tick(1); req = 1'b0;
        tick(4);
        req = 1'b1; tick(1); req = 1'b0;
        wait_idle(400);
`ifdef FADS_SCHED_MERGE_EN
        chk("overlap_npulse", rises.size(), 1);
        if (rises.size() >= 1 && falls.size() >= 1)
            chk("overlap_merged_width", falls[0] - rises[0], 35);
`else
        chk("overlap_npulse", rises.size(), 2);
        if (rises.size() >= 2) chk("overlap_spacing", rises[1] - rises[0], 35);
`endif
        chk("overlap_fired", fired, 2);

        // overflow
        do_clear();
        dly = 1000; dur = 1; gap = 0;
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 7) begin
                chk("ovf_ready_low", ready, 0);
                chk("ovf_pend_full", pend, 8);
            end
        end
        req = 1'b0;
        chk("ovf_dropped", dropped, 2);
        wait_idle(1500);
        chk("ovf_npulse", rises.size(), 8);
        chk("ovf_fired", fired, 8);

        // clear mid-pulse with three events queued
        do_clear();
        dly = 50; dur = 20; gap = 0;
        req = 1'b1; tick(4); req = 1'b0;
        wait_rise(1, 200);
        tick(5);
        chk("clr_pend_before", pend, 3);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_trig", trig, 0);
        chk("clr_pend", pend, 0);
        chk("clr_fired", fired, 0);
        chk("clr_dropped", dropped, 0);
        n_r = rises.size();
        tick(150);
        chk("clr_no_more_pulses", rises.size(), n_r);

        // asynchronous reset during a pulse
        dly = 10; dur = 40; gap = 0;
        rises.delete();
        req = 1'b1; tick(1); req = 1'b0;
        wait_rise(1, 100);
        tick(5);
        chk_en = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("arst_trig", trig, 0);
        chk("arst_pend", pend, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;
        tick(3);

        // randomized traffic against the model
        rises.delete();
        falls.delete();
        for (int i = 0; i < 4000; i++) begin
            req = ($urandom_range(99) < 35);
            en  = ($urandom_range(99) < 90);
            clr = ($urandom_range(999) < 5);
            if ($urandom_range(99) < 3) dly = $urandom_range(40);
            if ($urandom_range(99) < 3) dur = $urandom_range(8);
            if ($urandom_range(99) < 3) gap = $urandom_range(6);
            tick(1);
        end
        req = 1'b0;
        clr = 1'b0;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
